jtag_boundary_scan_tap: RTL and testbench

// Parametrised boundary-scan test access port with a full IEEE 1149.1 TAP FSM.

---
 rtl/jtag_boundary_scan_tap_if.sv | 29 ++
 rtl/jtag_boundary_scan_tap.sv | 148 ++++++++++++++
 tb/tb_jtag_boundary_scan_tap.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_boundary_scan_tap_if.sv
// Boundary-scan TAP signal bundle.
// Carries the serial test port (TMS, TDI, TDO, TDO_en) and the pad/core
// boundary signals. TCK and TRSTn are not in the bundle; they stay as plain
// ports on the TAP.
//   master : tester/pad/core side. Drives TMS, TDI, sys_in and core_out.
//   slave  : the TAP. Drives TDO, TDO_en, core_in and sys_out.
interface jtag_boundary_scan_tap_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 16
);
  logic             TMS;
  logic             TDI;
  logic             TDO;
  logic             TDO_en;
  logic [N_IN-1:0]  sys_in;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] core_out;
  logic [N_OUT-1:0] sys_out;

  modport master (
    output TMS, TDI, sys_in, core_out,
    input  TDO, TDO_en, core_in, sys_out
  );

  modport slave (
    input  TMS, TDI, sys_in, core_out,
    output TDO, TDO_en, core_in, sys_out
  );
endinterface

// File: rtl/jtag_boundary_scan_tap.sv
// IEEE 1149.1 boundary-scan TAP, parametrised.
// It contains the 16-state TAP controller, an IR_W-bit instruction register,
// a bypass register, a 32-bit IDCODE register, and an (N_IN+N_OUT)-bit
// boundary register with its update latch.
// The supported instructions are EXTEST=0, SAMPLE/PRELOAD=1, IDCODE=2 and
// INTEST=3. Every other opcode acts as BYPASS.
// Ports:
//   TCK   : test clock. Every flop updates on the rising edge.
//   TRSTn : asynchronous, active-low reset.
//   bus   : slave side of jtag_boundary_scan_tap_if. It carries TMS, TDI,
//           TDO and TDO_en, plus sys_in/core_in (pads to core) and
//           core_out/sys_out (core to pads).
module jtag_boundary_scan_tap #(
  parameter int          N_IN   = 16,
  parameter int          N_OUT  = 16,
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0A5B
) (
  input  logic                      TCK,
  input  logic                      TRSTn,
  jtag_boundary_scan_tap_if.slave   bus
);

  localparam int BSR_W = N_IN + N_OUT;

  localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(0);
  localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(2);
  localparam logic [IR_W-1:0] OP_INTEST = IR_W'(3);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t       state, state_nxt;
  logic             tdo_en;
  logic [IR_W-1:0]  ir_sh, ir;
  logic [BSR_W-1:0] bsr, upd;
  logic [31:0]      id_reg;
  logic             bypass_reg;
  logic             sel_bsr, sel_id;
  logic             tdo;

  always_comb begin
    state_nxt = state;
    unique case (state)
      TLR:      state_nxt = bus.TMS ? TLR    : RTI;
      RTI:      state_nxt = bus.TMS ? SEL_DR : RTI;
      SEL_DR:   state_nxt = bus.TMS ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = bus.TMS ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = bus.TMS ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = bus.TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = bus.TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = bus.TMS ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = bus.TMS ? SEL_DR : RTI;
      SEL_IR:   state_nxt = bus.TMS ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = bus.TMS ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = bus.TMS ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = bus.TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = bus.TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = bus.TMS ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = bus.TMS ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // TDO_en is registered from the next state, so it is high exactly for
  // the cycles spent in a Shift state.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      state  <= TLR;
      tdo_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      tdo_en <= (state_nxt == SH_DR) || (state_nxt == SH_IR);
    end
  end

  // The IR is loaded on the edge that enters Test-Logic-Reset, so IDCODE is
  // already selected during the first cycle spent there.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      ir_sh <= '0;
      ir    <= OP_IDCODE;
    end else begin
      if (state == CAP_IR)
        ir_sh <= IR_W'(1);
      else if (state == SH_IR)
        ir_sh <= {bus.TDI, ir_sh[IR_W-1:1]};

      if (state_nxt == TLR)
        ir <= OP_IDCODE;
      else if (state == UPD_IR)
        ir <= ir_sh;
    end
  end

  always_comb begin
    sel_bsr = (ir == OP_EXTEST) || (ir == OP_SAMPLE) || (ir == OP_INTEST);
    sel_id  = (ir == OP_IDCODE);
  end

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      bsr        <= '0;
      upd        <= '0;
      id_reg     <= '0;
      bypass_reg <= 1'b0;
    end else begin
      unique case (state)
        CAP_DR: begin
          bsr        <= {bus.sys_in, bus.core_out};
          id_reg     <= IDCODE;
          bypass_reg <= 1'b0;
        end
        SH_DR: begin
          if (sel_bsr)
            bsr <= {bus.TDI, bsr[BSR_W-1:1]};
          else if (sel_id)
            id_reg <= {bus.TDI, id_reg[31:1]};
          else
            bypass_reg <= bus.TDI;
        end
        UPD_DR: begin
          if (sel_bsr)
            upd <= bsr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR)
      tdo = ir_sh[0];
    else if (state == SH_DR)
      tdo = sel_bsr ? bsr[0] : (sel_id ? id_reg[0] : bypass_reg);
  end

  assign bus.TDO     = tdo;
  assign bus.TDO_en  = tdo_en;
  assign bus.core_in = (ir == OP_INTEST) ? upd[BSR_W-1:N_OUT] : bus.sys_in;
  assign bus.sys_out = (ir == OP_EXTEST) ? upd[N_OUT-1:0]     : bus.core_out;

endmodule

// File: tb/tb_jtag_boundary_scan_tap.sv
module tb_jtag_boundary_scan_tap;
  localparam int          N_IN  = 16;
  localparam int          N_OUT = 16;
  localparam logic [31:0] ID    = 32'h1000_0A5B;

  typedef bit bq_t[$];

  logic TCK   = 1'b0;
  logic TRSTn = 1'b0;

  jtag_boundary_scan_tap_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  jtag_boundary_scan_tap #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IR_W(4), .IDCODE(ID)
  ) dut (
    .TCK(TCK),
    .TRSTn(TRSTn),
    .bus(bus)
  );

  always #5 TCK = ~TCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model. The TAP is a transition table. Each data register is
  // a bit queue with the LSB at the front: a shift pops the front bit toward
  // TDO and pushes TDI onto the back.
  // State numbers: 0 TLR, 1 RTI, 2..8 the DR column, 9..15 the IR column.
  int  nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int  nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int  m_st;
  int  m_ir;
  bq_t irsh_q, bsr_q, id_q, byp_q;
  logic [31:0] m_upd;

  function automatic bq_t to_q(input logic [31:0] v, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(v[i]);
    return q;
  endfunction

  function automatic logic [31:0] from_q(input bq_t q);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  function automatic bit is_bsr_op(input int op);
    return (op == 0) || (op == 1) || (op == 3);
  endfunction

  always @(posedge TCK or negedge TRSTn) begin
    int nx;
    if (!TRSTn) begin
      m_st = 0; m_ir = 2; m_upd = '0;
      irsh_q = to_q(0, 4); bsr_q = to_q(0, 32); id_q = to_q(0, 32); byp_q = to_q(0, 1);
    end else begin
      nx = bus.TMS ? nxt1[m_st] : nxt0[m_st];
      case (m_st)
        3: begin
          bsr_q = to_q({bus.sys_in, bus.core_out}, 32);
          id_q  = to_q(ID, 32);
          byp_q = to_q(0, 1);
        end
        4: begin
          if (is_bsr_op(m_ir)) begin bsr_q.delete(0); bsr_q.push_back(bus.TDI); end
          else if (m_ir == 2)  begin id_q.delete(0);  id_q.push_back(bus.TDI);  end
          else                 begin byp_q.delete(0); byp_q.push_back(bus.TDI); end
        end
        8:  if (is_bsr_op(m_ir)) m_upd = from_q(bsr_q);
        10: irsh_q = to_q(1, 4);
        11: begin irsh_q.delete(0); irsh_q.push_back(bus.TDI); end
        15: m_ir = int'(from_q(irsh_q));
        default: ;
      endcase
      if (nx == 0) m_ir = 2;
      m_st = nx;
    end
  end

  // Compare process: checks every cycle, halfway through the low phase.
  always @(negedge TCK) begin
    logic        e_tdo;
    logic [15:0] e_ci, e_so;
    #2;
    if (TRSTn) begin
      e_tdo = 1'b0;
      if (m_st == 11) e_tdo = irsh_q[0];
      else if (m_st == 4) e_tdo = is_bsr_op(m_ir) ? bsr_q[0] : ((m_ir == 2) ? id_q[0] : byp_q[0]);
      e_ci = (m_ir == 3) ? m_upd[31:16] : bus.sys_in;
      e_so = (m_ir == 0) ? m_upd[15:0]  : bus.core_out;
      chk("cyc_tdo_en", {31'b0, bus.TDO_en}, {31'b0, (m_st == 4) || (m_st == 11)});
      chk("cyc_tdo", {31'b0, bus.TDO}, {31'b0, e_tdo});
      chk("cyc_core_in", {16'b0, bus.core_in}, {16'b0, e_ci});
      chk("cyc_sys_out", {16'b0, bus.sys_out}, {16'b0, e_so});
    end
  end

  task automatic tick(input logic tms, input logic tdi = 1'b0);
    @(negedge TCK);
    bus.TMS = tms;
    bus.TDI = tdi;
  endtask

  task automatic settle();
    @(negedge TCK);
    #1;
  endtask

  // Starts in Run-Test/Idle and ends in Run-Test/Idle.
  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
    cap = '0;
    tick(1); tick(1); tick(0); tick(0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i]);
      #1 cap[i] = bus.TDO;
    end
    tick(1); tick(0);
  endtask

  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    tick(1); tick(0); tick(0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      #1 dout[i] = bus.TDO;
    end
    tick(1); tick(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  cap;
    logic [31:0] dout;
    bus.TMS = 1'b1; bus.TDI = 1'b0;
    bus.sys_in = 16'h5A5A; bus.core_out = 16'h3C3C;
    repeat (2) @(posedge TCK);
    #1;
    chk("rst_tdo", {31'b0, bus.TDO}, 32'h0);
    chk("rst_tdo_en", {31'b0, bus.TDO_en}, 32'h0);
    chk("rst_core_in", {16'b0, bus.core_in}, 32'h5A5A);
    chk("rst_sys_out", {16'b0, bus.sys_out}, 32'h3C3C);
    @(negedge TCK); #1 TRSTn = 1'b1;
    tick(0);

    scan_dr(32'h0, 32, dout);
    chk("idcode_after_reset", dout, 32'h1000_0A5B);

    load_ir(4'hF, cap);
    chk("ir_capture", {28'b0, cap}, 32'h1);
    scan_dr(32'h0000_00A5, 9, dout);
    chk("bypass_a5", dout, 32'h0000_014A);

    bus.sys_in = 16'h1234; bus.core_out = 16'hBEEF;
    load_ir(4'h1, cap);
    scan_dr(32'h0000_00FF, 32, dout);
    chk("sample_capture", dout, 32'h1234_BEEF);
    bus.core_out = 16'hFF00;
    load_ir(4'h0, cap);
    settle();
    chk("extest_sys_out", {16'b0, bus.sys_out}, 32'h0000_00FF);
    chk("extest_core_in", {16'b0, bus.core_in}, 32'h0000_1234);

    load_ir(4'h1, cap);
    scan_dr(32'hC3C3_0000, 32, dout);
    chk("sample_capture2", dout, 32'h1234_FF00);
    load_ir(4'h3, cap);
    settle();
    chk("intest_core_in", {16'b0, bus.core_in}, 32'h0000_C3C3);
    chk("intest_sys_out", {16'b0, bus.sys_out}, 32'h0000_FF00);

    // Partial shift, park in Pause-DR, then an asynchronous reset.
    tick(1); tick(0); tick(0);
    tick(0, 1'b1); tick(0, 1'b1); tick(0, 1'b0);
    tick(1); tick(0); tick(0);
    settle();
    chk("pause_tdo_en", {31'b0, bus.TDO_en}, 32'h0);
    chk("pause_core_in", {16'b0, bus.core_in}, 32'h0000_C3C3);
    #2 TRSTn = 1'b0;
    #1;
    chk("trst_core_in", {16'b0, bus.core_in}, 32'h0000_1234);
    chk("trst_tdo_en", {31'b0, bus.TDO_en}, 32'h0);
    @(negedge TCK); #1 TRSTn = 1'b1;
    bus.TMS = 1'b1;
    tick(0);

    load_ir(4'h1, cap);
    scan_dr(32'hC3C3_00FF, 32, dout);
    chk("sample_capture3", dout, 32'h1234_FF00);
    load_ir(4'h7, cap);
    scan_dr(32'h0000_000B, 4, dout);
    chk("undef_one_bit_dr", dout, 32'h0000_0006);
    load_ir(4'h0, cap);
    settle();
    chk("extest2_sys_out", {16'b0, bus.sys_out}, 32'h0000_00FF);
    repeat (5) tick(1);
    settle();
    chk("tms_reset_sys_out", {16'b0, bus.sys_out}, 32'h0000_FF00);
    chk("tms_reset_core_in", {16'b0, bus.core_in}, 32'h0000_1234);
    tick(0);
    scan_dr(32'h0, 32, dout);
    chk("idcode_after_tms_reset", dout, 32'h1000_0A5B);

    repeat (2) @(negedge TCK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
